rnl_neuron_body: RTL and testbench
==================================

# rnl_neuron_body

Neuron body for the RNL temporal column, directly downstream of the per-input synapse FSMs. Each cycle it counts the unary synapse outputs it receives and adds them to a body potential. When the potential reaches the threshold, it emits one output spike per gamma cycle: a WMAX-cycle pulse, the same encoding the next layer's synapses consume. It also emits a 1-cycle post-synaptic event for STDP and, optionally, the spike time.

## Interface
- NSYN, 8, number of synapse inputs
- WRES, 3, weight resolution; WMAX = 2^WRES-1 sets output pulse width
- PRES, 6, body-potential width; must satisfy 2^PRES-1 >= NSYN*WMAX
- TRES, 3, spike-time counter width
- clk  input  1  unit clock
- rstb  input  1  reset, synchronous, active-low; clock clk
- grst  input  1  1-cycle gamma-clock pulse; starts a new gamma cycle
- syn_in  input  NSYN  unary synapse outputs, one bit per synapse
- theta  input  PRES  firing threshold; 0 disables firing
- spike_out  output  1  WMAX-cycle output spike pulse
- post_spike  output  1  1-cycle pulse on the first cycle of spike_out, for STDP
- spike_time  output  TRES  gamma-relative fire time; all-ones when no spike
- fired  output  1  high from fire until next grst/reset

## Operation
- States: INTEG, FIRE, DONE.
- Reset (rstb=0):
  - state=DONE, potential=0, time counter=0, pulse counter=0.
  - spike_out=0, post_spike=0, fired=0, spike_time=all-ones.
- grst=1 (rstb=1), in any state:
  - state=INTEG, potential=0, time=0, fired=0, spike_time=all-ones, spike_out=0.
  - syn_in is ignored that cycle.
  - grst aborts an in-progress FIRE pulse.
- INTEG:
  - sum = potential + popcount(syn_in), saturating at 2^PRES-1.
  - potential <= sum.
  - If theta!=0 and sum>=theta: go to FIRE, fired<=1, spike_time<=time, pulse counter<=WMAX.
- FIRE:
  - spike_out=1 and the pulse counter decrements each cycle.
  - When the counter reaches 1, go to DONE on the next edge.
  - Exactly WMAX high cycles.
  - Potential is frozen; syn_in is ignored.
- DONE:
  - Outputs are held; syn_in is ignored until grst.
  - At most one spike per gamma cycle.
- Time counter:
  - Increments every non-grst cycle.
  - Saturates at 2^TRES-1; it does not wrap.
  - A fire at saturated time reports all-ones with fired=1.

## Timing
- t=0 is the first cycle after the grst cycle.
- Fire decision uses the same-cycle syn_in (the combinational sum).
- Output latency:
  - Fire decided at cycle t: spike_time=t and fired=1 visible from t+1.
  - spike_out is high over t+1..t+WMAX.
  - post_spike is high at t+1 only.
- All outputs are registered.
- The pulse is not truncated by reaching time saturation; only grst or reset aborts it.

## Configuration
- NEURON_SPIKE_TIME_EN defined:
  - The time counter and spike_time register are built.
  - Behaviour is as above.
- NEURON_SPIKE_TIME_EN undefined:
  - The counter and register are removed.
  - spike_time is tied to all-ones.
  - All other behaviour is identical.

## Structure
- Shared package neuron_pkg holds:
  - typedef enum logic [1:0] for INTEG/FIRE/DONE;
  - a WMAX function of WRES;
  - a saturating-add helper.
- Sub-module unary_popcount (parameter NSYN): combinational adder tree, output width $clog2(NSYN+1).

## Test plan
NSYN=4, WRES=3 (WMAX=7), PRES=6, TRES=3 unless stated.
- Reset, then idle: all outputs 0 except spike_time=3'b111; state DONE; syn_in=4'b1111 causes no change.
- theta=5, grst, then syn_in=4'b0011 from t=0: potential 2,4,6 -> fire at t=2. spike_time=2 and fired=1 from t=3; spike_out high t=3..9; post_spike at t=3 only.
- Same stimulus with syn_in held high through t=20: exactly one 7-cycle pulse; no second spike before the next grst.
- grst at t=5 mid-pulse: spike_out drops next cycle, fired=0, spike_time=3'b111, potential=0. A new fire is possible.
- theta=0, syn_in=4'b1111 for 20 cycles: no spike; time saturates at 7; spike_time stays 7.
- theta=63, NSYN=8, PRES=6, syn_in all-ones for 10 cycles: potential saturates at 63, then fires; no wrap to a low value.

Source files
------------

// File: rtl/rnl_neuron_body_pkg.sv
// Shared types and helpers for the RNL neuron body: FSM state encoding,
// output pulse width as a function of weight resolution, and a saturating add.
package neuron_pkg;

  typedef enum logic [1:0] {
    ST_INTEG = 2'd0,
    ST_FIRE  = 2'd1,
    ST_DONE  = 2'd2
  } neuron_state_e;

  function automatic int unsigned wmax_f(input int unsigned wres);
    return (32'd1 << wres) - 32'd1;
  endfunction

  function automatic int unsigned sat_add(input int unsigned a,
                                          input int unsigned b,
                                          input int unsigned lim);
    int unsigned s;
    s = a + b;
    return (s > lim) ? lim : s;
  endfunction

endpackage

// File: rtl/rnl_neuron_body_if.sv
// Gamma-cycle control, synapse inputs and spike outputs of the neuron body.
interface rnl_neuron_body_if #(
  parameter int NSYN = 8,
  parameter int PRES = 6,
  parameter int TRES = 3
);
  logic            grst;
  logic [NSYN-1:0] syn_in;
  logic [PRES-1:0] theta;
  logic            spike_out;
  logic            post_spike;
  logic [TRES-1:0] spike_time;
  logic            fired;

  modport master (output grst, syn_in, theta,
                  input  spike_out, post_spike, spike_time, fired);
  modport slave  (input  grst, syn_in, theta,
                  output spike_out, post_spike, spike_time, fired);
endinterface

// File: rtl/rnl_neuron_body_unary_popcount.sv
// Counts the set bits of the unary synapse vector in one combinational pass.
module unary_popcount #(
  parameter int NSYN = 8,
  parameter int CW   = $clog2(NSYN + 1)
) (
  input  logic [NSYN-1:0] i_bits,
  output logic [CW-1:0]   o_count
);

  always_comb begin
    // NOTE: assign a default before the loop so no path leaves o_count unassigned (no latch).
    o_count = '0;
    for (int i = 0; i < NSYN; i++) begin
      o_count = o_count + CW'(i_bits[i]);
    end
  end

endmodule

// File: rtl/rnl_neuron_body.sv
// RNL neuron body: integrates unary synapse counts, fires one WMAX-cycle pulse per
// gamma cycle. Define NEURON_SPIKE_TIME_EN to build the spike-time counter/register.
module rnl_neuron_body
  import neuron_pkg::*;
#(
  parameter int NSYN = 8,
  parameter int WRES = 3,
  parameter int PRES = 6,
  parameter int TRES = 3
) (
  input  logic                clk,
  input  logic                rstb,
  rnl_neuron_body_if.slave    bus
);

  localparam int unsigned WMAX = wmax_f(WRES);
  localparam int unsigned PMAX = (32'd1 << PRES) - 32'd1;
  localparam int          CW   = $clog2(NSYN + 1);

  neuron_state_e   r_state, w_state_nxt;
  logic [PRES-1:0] r_pot, w_pot_nxt, w_sum;
  logic [WRES-1:0] r_cnt, w_cnt_nxt;
  logic            r_spike, w_spike_nxt;
  logic            r_post, w_post_nxt;
  logic            r_fired, w_fired_nxt;
  logic [CW-1:0]   w_count;

  unary_popcount #(.NSYN(NSYN), .CW(CW)) u_popcount (
    .i_bits  (bus.syn_in),
    .o_count (w_count)
  );

  assign w_sum = PRES'(sat_add(32'(r_pot), 32'(w_count), PMAX));

  always_comb begin
    w_state_nxt = r_state;
    w_pot_nxt   = r_pot;
    w_cnt_nxt   = r_cnt;
    w_spike_nxt = r_spike;
    w_post_nxt  = 1'b0;
    w_fired_nxt = r_fired;
    if (bus.grst) begin
      // A new gamma cycle wins over everything, including a pulse in flight.
      w_state_nxt = ST_INTEG;
      w_pot_nxt   = '0;
      w_cnt_nxt   = '0;
      w_spike_nxt = 1'b0;
      w_fired_nxt = 1'b0;
    end else begin
      unique case (r_state)
        ST_INTEG: begin
          w_pot_nxt = w_sum;
          if ((bus.theta != '0) && (w_sum >= bus.theta)) begin
            w_state_nxt = ST_FIRE;
            w_cnt_nxt   = WRES'(WMAX);
            w_spike_nxt = 1'b1;
            w_post_nxt  = 1'b1;
            w_fired_nxt = 1'b1;
          end
        end
        ST_FIRE: begin
          w_cnt_nxt = r_cnt - WRES'(1);
          if (r_cnt == WRES'(1)) begin
            w_state_nxt = ST_DONE;
            w_spike_nxt = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: reset here is synchronous (sampled on clk), and state uses non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_state <= ST_DONE;
      r_pot   <= '0;
      r_cnt   <= '0;
      r_spike <= 1'b0;
      r_post  <= 1'b0;
      r_fired <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pot   <= w_pot_nxt;
      r_cnt   <= w_cnt_nxt;
      r_spike <= w_spike_nxt;
      r_post  <= w_post_nxt;
      r_fired <= w_fired_nxt;
    end
  end

  assign bus.spike_out  = r_spike;
  assign bus.post_spike = r_post;
  assign bus.fired      = r_fired;

`ifdef NEURON_SPIKE_TIME_EN
  logic [TRES-1:0] r_time;
  logic [TRES-1:0] r_spike_time;

  // The time counter saturates so a late fire reports all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_time       <= '0;
      r_spike_time <= '1;
    end else if (bus.grst) begin
      r_time       <= '0;
      r_spike_time <= '1;
    end else begin
      if (r_time != '1) r_time <= r_time + TRES'(1);
      if (w_post_nxt)   r_spike_time <= r_time;
    end
  end

  assign bus.spike_time = r_spike_time;
`else
  assign bus.spike_time = '1;
`endif

endmodule

// File: tb/tb_rnl_neuron_body.sv
// Self-checking bench for rnl_neuron_body: vector table, corner sequences and
// randomized gamma cycles against a fire-time based reference model.
module tb_rnl_neuron_body;

`ifdef NEURON_SPIKE_TIME_EN
  localparam bit TIME_EN = 1'b1;
`else
  localparam bit TIME_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstb = 1'b0;
  always #5 clk = ~clk;

  rnl_neuron_body_if #(.NSYN(4), .PRES(6), .TRES(3)) i4 ();
  rnl_neuron_body_if #(.NSYN(8), .PRES(6), .TRES(3)) i8 ();

  rnl_neuron_body #(.NSYN(4), .WRES(3), .PRES(6), .TRES(3)) dut4 (
    .clk(clk), .rstb(rstb), .bus(i4.slave));
  rnl_neuron_body #(.NSYN(8), .WRES(3), .PRES(6), .TRES(3)) dut8 (
    .clk(clk), .rstb(rstb), .bus(i8.slave));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (time %0t)", name, act, exp, $time);
    end
  endtask

  function automatic int exp_time(input int t);
    if (!TIME_EN || t < 0) return 7;
    return (t > 7) ? 7 : t;
  endfunction

  // Reference model: remembers the fire time within the current gamma cycle and
  // derives every output from the distance to it.
  bit m_active = 1'b0;
  int m_pot    = 0;
  int m_t      = 0;
  int m_fire_t = -1;

  task automatic cycle4(input bit g, input logic [3:0] s, input logic [5:0] th,
                        input string tag);
    int cur;
    i4.grst = g; i4.syn_in = s; i4.theta = th;
    @(posedge clk); #1;
    cur = -100;
    if (g) begin
      m_active = 1'b1; m_pot = 0; m_t = 0; m_fire_t = -1;
    end else begin
      if (m_active && m_fire_t < 0) begin
        m_pot = m_pot + $countones(s);
        if (m_pot > 63) m_pot = 63;
        if (th != 0 && m_pot >= int'(th)) m_fire_t = m_t;
      end
      cur = m_t;
      m_t++;
    end
    check({tag, ".fired"},      int'(i4.fired),      int'(m_fire_t >= 0));
    check({tag, ".spike_out"},  int'(i4.spike_out),
          int'(m_fire_t >= 0 && cur - m_fire_t < 7));
    check({tag, ".post_spike"}, int'(i4.post_spike), int'(m_fire_t >= 0 && m_fire_t == cur));
    check({tag, ".spike_time"}, int'(i4.spike_time), exp_time(m_fire_t));
  endtask

  typedef struct {
    bit         grst;
    logic [3:0] syn;
    logic [5:0] theta;
    bit         e_spike;
    bit         e_post;
    bit         e_fired;
    int         e_ftime;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input bit g, input logic [3:0] s, input bit sp,
                         input bit po, input bit fi, input int ft);
    vec_t v;
    v.grst = g; v.syn = s; v.theta = 6'd5;
    v.e_spike = sp; v.e_post = po; v.e_fired = fi; v.e_ftime = ft;
    vecs.push_back(v);
  endtask

  initial begin
    i4.grst = 1'b0; i4.syn_in = '0; i4.theta = '0;
    i8.grst = 1'b0; i8.syn_in = '0; i8.theta = '0;
    rstb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.spike_out",  int'(i4.spike_out),  0);
    check("reset.post_spike", int'(i4.post_spike), 0);
    check("reset.fired",      int'(i4.fired),      0);
    check("reset.spike_time", int'(i4.spike_time), 7);
    rstb = 1'b1;

    // After reset the body sits in DONE: full input activity changes nothing.
    for (int i = 0; i < 6; i++) cycle4(1'b0, 4'b1111, 6'd5, "idle");

    // theta=5, syn_in=0011: potential 2,4,6 -> fire at t=2, pulse over t=3..9.
    add_vec(1'b1, 4'b0000, 0, 0, 0, -1);
    add_vec(1'b0, 4'b0011, 0, 0, 0, -1);
    add_vec(1'b0, 4'b0011, 0, 0, 0, -1);
    add_vec(1'b0, 4'b0011, 1, 1, 1, 2);
    for (int i = 0; i < 6; i++) add_vec(1'b0, 4'b0011, 1, 0, 1, 2);
    add_vec(1'b0, 4'b0011, 0, 0, 1, 2);
    add_vec(1'b0, 4'b1111, 0, 0, 1, 2);
    foreach (vecs[i]) begin
      i4.grst = vecs[i].grst; i4.syn_in = vecs[i].syn; i4.theta = vecs[i].theta;
      @(posedge clk); #1;
      check($sformatf("vec%0d.spike_out", i),  int'(i4.spike_out),  int'(vecs[i].e_spike));
      check($sformatf("vec%0d.post_spike", i), int'(i4.post_spike), int'(vecs[i].e_post));
      check($sformatf("vec%0d.fired", i),      int'(i4.fired),      int'(vecs[i].e_fired));
      check($sformatf("vec%0d.spike_time", i), int'(i4.spike_time), exp_time(vecs[i].e_ftime));
    end

    // Input held through t=20: only one pulse per gamma cycle.
    cycle4(1'b1, 4'b0000, 6'd5, "hold");
    for (int t = 0; t <= 20; t++) cycle4(1'b0, 4'b0011, 6'd5, "hold");

    // grst at t=5 aborts the pulse; the next gamma cycle fires again.
    cycle4(1'b1, 4'b0000, 6'd5, "abort");
    for (int t = 0; t < 5; t++) cycle4(1'b0, 4'b0011, 6'd5, "abort");
    cycle4(1'b1, 4'b0011, 6'd5, "abort");
    for (int t = 0; t < 12; t++) cycle4(1'b0, 4'b0011, 6'd5, "refire");

    // theta=0 never fires; a late enable then fires at the saturated time.
    cycle4(1'b1, 4'b0000, 6'd0, "theta0");
    for (int t = 0; t < 20; t++) cycle4(1'b0, 4'b1111, 6'd0, "theta0");
    for (int t = 0; t < 9; t++)  cycle4(1'b0, 4'b0000, 6'd1, "latefire");

    // Randomized gamma cycles.
    begin
      logic [5:0] th;
      th = 6'd8;
      cycle4(1'b1, 4'b0000, th, "rand");
      for (int i = 0; i < 500; i++) begin
        bit g;
        g = ($urandom_range(0, 19) == 0);
        if (g) begin
          case ($urandom_range(0, 9))
            0:       th = 6'd0;
            9:       th = 6'd63;
            default: th = 6'($urandom_range(1, 20));
          endcase
        end
        cycle4(g, 4'($urandom), th, "rand");
      end
    end

    // NSYN=8 at theta=63: sums 8..56 then saturate at 63 and fire at t=7.
    i8.theta = 6'd63; i8.syn_in = '0; i8.grst = 1'b1;
    @(posedge clk); #1;
    i8.grst = 1'b0; i8.syn_in = 8'hFF;
    for (int t = 0; t < 10; t++) begin
      @(posedge clk); #1;
      check($sformatf("sat8.t%0d.fired", t),      int'(i8.fired),      int'(t >= 7));
      check($sformatf("sat8.t%0d.spike_out", t),  int'(i8.spike_out),  int'(t >= 7));
      check($sformatf("sat8.t%0d.post_spike", t), int'(i8.post_spike), int'(t == 7));
      check($sformatf("sat8.t%0d.spike_time", t), int'(i8.spike_time),
            (t >= 7) ? exp_time(7) : 7);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
